// File: rtl/matrix_alu_pkg.sv
// Shared definitions for the sequential matrix ALU: op codes, FSM states
// and the counter-width helper.
package matrix_alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_KRON = 3'b011;
  localparam logic [2:0] OP_TRN  = 3'b100;

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  // Bits needed for a counter that runs 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/matrix_mac.sv
// Shared datapath: signed WORD x WORD product folded into an OUT_W
// accumulator. o_sum is the value of the current step; the accumulator
// keeps it for the next step unless this step finishes an element.
module matrix_mac
  import matrix_alu_pkg::*;
#(
  parameter int WORD  = 8,
  parameter int OUT_W = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    i_clr,
  input  logic                    i_en,
  input  logic                    i_sub,
  input  logic                    i_last,
  input  logic signed [WORD-1:0]  i_a,
  input  logic signed [WORD-1:0]  i_b,
  input  logic [OUT_W-1:0]        i_init,
  output logic [OUT_W-1:0]        o_sum
);

  logic signed [2*WORD-1:0] w_p;
  logic [OUT_W-1:0]         w_prod;
  logic [OUT_W-1:0]         w_base;
  logic [OUT_W-1:0]         r_acc;

  // The exact product is sign-extended (or wrapped) to the result width.
  assign w_p    = i_a * i_b;
  assign w_prod = OUT_W'(w_p);
  assign w_base = r_acc + i_init;
  assign o_sum  = i_sub ? (w_base - w_prod) : (w_base + w_prod);

  // Accumulator: cleared on reset/new request and after an element's last step.
  always_ff @(posedge clk) begin
    if (!resetn || i_clr) r_acc <= '0;
    else if (i_en)        r_acc <= i_last ? '0 : o_sum;
  end

endmodule

// File: rtl/matrix_alu_seq.sv
// Sequential matrix ALU: add/sub/mul/kron/transpose over one shared MAC,
// one step per clock, with valid/ready on both request and result sides.
module matrix_alu_seq
  import matrix_alu_pkg::*;
#(
  parameter int WORD  = 8,
  parameter int AROWS = 2,
  parameter int ACOLS = 2,
  parameter int BROWS = 2,
  parameter int BCOLS = 2,
  parameter int OUT_W = 16
) (
  input  logic                                    clk,
  input  logic                                    resetn,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [2:0]                              op,
  input  logic [AROWS*ACOLS*WORD-1:0]             A,
  input  logic [BROWS*BCOLS*WORD-1:0]             B,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [AROWS*ACOLS*BROWS*BCOLS*OUT_W-1:0] C,
  output logic                                    err
);

  localparam int NC    = AROWS*ACOLS*BROWS*BCOLS;
  localparam int MAX_A = (AROWS > ACOLS) ? AROWS : ACOLS;
  localparam int MAX_B = (BROWS > BCOLS) ? BROWS : BCOLS;
  localparam int MAXD  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = cnt_w(MAXD);
  localparam bit ADDSUB_OK = (AROWS == BROWS) && (ACOLS == BCOLS);
  localparam bit MUL_OK    = (ACOLS == BROWS);

  state_t                         r_state;
  logic                           r_in_ready, r_out_valid, r_err;
  logic [2:0]                     r_op;
  logic [AROWS*ACOLS*WORD-1:0]    r_a;
  logic [BROWS*BCOLS*WORD-1:0]    r_b;
  logic [NC*OUT_W-1:0]            r_c;
  // Nested loop counters, index 0 innermost; w_max holds each loop's last value.
  logic [3:0][CW-1:0]             r_cnt;
  logic [3:0][CW-1:0]             w_max;
  logic [4:0]                     w_carry;
  int                             w_c0, w_c1, w_c2, w_c3;
  int                             w_ia, w_ib, w_io;
  logic                           w_a_is_b, w_b_one, w_init_a;
  logic signed [WORD-1:0]         w_ea, w_eb, w_ma, w_mb;
  logic [OUT_W-1:0]               w_init, w_sum;
  logic                           w_sub, w_last, w_legal, w_accept;

  assign w_c0 = int'(r_cnt[0]);
  assign w_c1 = int'(r_cnt[1]);
  assign w_c2 = int'(r_cnt[2]);
  assign w_c3 = int'(r_cnt[3]);
  assign w_accept = r_in_ready && in_valid;

  // Legality of the request being offered, judged on the raw op input.
  always_comb begin
    w_legal = 1'b0;
    case (op)
      OP_ADD, OP_SUB:  w_legal = ADDSUB_OK;
      OP_MUL:          w_legal = MUL_OK;
      OP_KRON, OP_TRN: w_legal = 1'b1;
      default:         w_legal = 1'b0;
    endcase
  end

  // Per-op loop bounds, operand/result indices and MAC operand selection.
  always_comb begin
    w_max    = '0;
    w_ia     = 0;
    w_ib     = 0;
    w_io     = 0;
    w_sub    = 1'b0;
    w_last   = 1'b1;
    w_a_is_b = 1'b0;
    w_b_one  = 1'b0;
    w_init_a = 1'b0;
    case (r_op)
      OP_ADD, OP_SUB: begin
        // A[i] rides in as the seed, B[i]*1 is added or subtracted.
        w_max[0] = CW'(ACOLS-1);
        w_max[1] = CW'(AROWS-1);
        w_ia     = w_c1*ACOLS + w_c0;
        w_ib     = w_ia;
        w_io     = w_ia;
        w_a_is_b = 1'b1;
        w_b_one  = 1'b1;
        w_init_a = 1'b1;
        w_sub    = (r_op == OP_SUB);
      end
      OP_MUL: begin
        // loops: row (2) / col (1) / k (0)
        w_max[0] = CW'(ACOLS-1);
        w_max[1] = CW'(BCOLS-1);
        w_max[2] = CW'(AROWS-1);
        w_ia     = w_c2*ACOLS + w_c0;
        w_ib     = w_c0*BCOLS + w_c1;
        w_io     = w_c2*BCOLS + w_c1;
        w_last   = (r_cnt[0] == w_max[0]);
      end
      OP_KRON: begin
        // loops: ra (3) / rb (2) / ca (1) / cb (0) so C fills in order
        w_max[0] = CW'(BCOLS-1);
        w_max[1] = CW'(ACOLS-1);
        w_max[2] = CW'(BROWS-1);
        w_max[3] = CW'(AROWS-1);
        w_ia     = w_c3*ACOLS + w_c1;
        w_ib     = w_c2*BCOLS + w_c0;
        w_io     = ((w_c3*BROWS + w_c2)*ACOLS + w_c1)*BCOLS + w_c0;
      end
      OP_TRN: begin
        w_max[0] = CW'(ACOLS-1);
        w_max[1] = CW'(AROWS-1);
        w_ia     = w_c1*ACOLS + w_c0;
        w_io     = w_c0*AROWS + w_c1;
        w_b_one  = 1'b1;
      end
      default: ;
    endcase
    w_ea   = r_a[w_ia*WORD +: WORD];
    w_eb   = r_b[w_ib*WORD +: WORD];
    w_ma   = w_a_is_b ? w_eb : w_ea;
    w_mb   = w_b_one ? WORD'(1) : w_eb;
    w_init = w_init_a ? OUT_W'(w_ea) : '0;
  end

  // Ripple carry through the nested counters; w_carry[4] marks the final step.
  always_comb begin
    w_carry[0] = 1'b1;
    for (int i = 0; i < 4; i++)
      w_carry[i+1] = w_carry[i] && (r_cnt[i] == w_max[i]);
  end

  matrix_mac #(.WORD(WORD), .OUT_W(OUT_W)) u_mac (
    .clk    (clk),
    .resetn (resetn),
    .i_clr  (w_accept),
    .i_en   (r_state == COMPUTE),
    .i_sub  (w_sub),
    .i_last (w_last),
    .i_a    (w_ma),
    .i_b    (w_mb),
    .i_init (w_init),
    .o_sum  (w_sum)
  );

  // Control FSM with registered handshake outputs, operand latches and result.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_c         <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op       <= op;
            r_a        <= A;
            r_b        <= B;
            r_c        <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            if (w_legal) begin
              r_state <= COMPUTE;
              r_err   <= 1'b0;
            end else begin
              r_state     <= DONE;
              r_err       <= 1'b1;
              r_out_valid <= 1'b1;
            end
          end
        end
        COMPUTE: begin
          for (int i = 0; i < 4; i++)
            if (w_carry[i])
              r_cnt[i] <= (r_cnt[i] == w_max[i]) ? '0 : r_cnt[i] + 1'b1;
          if (w_last) r_c[w_io*OUT_W +: OUT_W] <= w_sum;
          if (w_carry[4]) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_err       <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign err       = r_err;
  assign C         = r_c;

endmodule
